// File: rtl/rom_fetch_stage.sv
// Instruction fetch stage in front of a registered-address 32-bit ROM.
// It issues sequential word reads, buffers results in a 2-entry skid FIFO,
// and flushes all work on a redirect.
module rom_fetch_stage #(
    parameter int unsigned  DEPTH      = 512,
    parameter logic [31:0]  RESET_PC   = 32'h0000_0000,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic [ADDR_WIDTH-1:0] o_rom_addr,
    input  logic [31:0]           i_rom_data,
    input  logic                  i_redirect,
    input  logic [31:0]           i_redirect_pc,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [31:0]           o_instr,
    output logic [31:0]           o_pc,
    output logic                  o_fault
);

    localparam logic [31:0] PC_LIMIT = 32'(DEPTH * 4);

    typedef enum logic {
        MODE_RUN   = 1'b0,
        MODE_FAULT = 1'b1
    } mode_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             inflight_v_q, inflight_v_d;
    logic [31:0]      inflight_pc_q, inflight_pc_d;
    entry_t [1:0]     fifo_q, fifo_d;
    logic [1:0]       count_q, count_d;
    mode_e            mode_q, mode_d;

    logic             pop;
    logic             push;
    logic             issue;
    logic             space_ok;
    logic             pc_ok;
    logic             tgt_ok;
    logic [2:0]       occ_after;
    logic [1:0]       push_idx;
    entry_t           new_entry;

    // Handshake and issue qualification
    assign pop       = (count_q != 2'd0) & i_ready & ~i_redirect;
    assign push      = inflight_v_q & ~i_redirect;
    // Occupancy once this cycle's capture and pop settle; a new issue needs a free slot
    assign occ_after = 3'(count_q) + 3'(inflight_v_q) - 3'(pop);
    assign space_ok  = occ_after < 3'd2;
    assign pc_ok     = (fetch_pc_q < PC_LIMIT) && (fetch_pc_q[1:0] == 2'b00);
    assign tgt_ok    = (i_redirect_pc < PC_LIMIT) && (i_redirect_pc[1:0] == 2'b00);
    assign issue     = (mode_q == MODE_RUN) & ~i_redirect & space_ok & pc_ok;
    assign push_idx  = count_q - 2'(pop);
    assign new_entry = '{pc: inflight_pc_q, instr: i_rom_data};

    // The ROM registers this address, so a redirect target must bypass fetch_pc
    assign o_rom_addr = i_redirect ? i_redirect_pc[ADDR_WIDTH+1:2]
                                   : fetch_pc_q[ADDR_WIDTH+1:2];

    assign o_valid = (count_q != 2'd0);
    assign o_pc    = fifo_q[0].pc;
    assign o_instr = fifo_q[0].instr;
    assign o_fault = (mode_q == MODE_FAULT) & (count_q == 2'd0) & ~inflight_v_q;

    // Next-state logic
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_v_d  = inflight_v_q;
        inflight_pc_d = inflight_pc_q;
        fifo_d        = fifo_q;
        count_d       = count_q;
        mode_d        = mode_q;

        if (i_redirect) begin
            count_d = 2'd0;
            if (tgt_ok) begin
                mode_d        = MODE_RUN;
                inflight_v_d  = 1'b1;
                inflight_pc_d = i_redirect_pc;
                fetch_pc_d    = i_redirect_pc + 32'd4;
            end else begin
                mode_d       = MODE_FAULT;
                inflight_v_d = 1'b0;
                fetch_pc_d   = i_redirect_pc;
            end
        end else begin
            if (pop) begin
                fifo_d[0] = fifo_q[1];
            end
            if (push) begin
                if (push_idx == 2'd0) begin
                    fifo_d[0] = new_entry;
                end else begin
                    fifo_d[1] = new_entry;
                end
            end
            count_d      = count_q + 2'(push) - 2'(pop);
            inflight_v_d = issue;
            if (issue) begin
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 32'd4;
            end else if ((mode_q == MODE_RUN) && space_ok && !pc_ok) begin
                mode_d = MODE_FAULT;
            end
        end
    end

    // State registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_v_q  <= 1'b0;
            inflight_pc_q <= 32'd0;
            fifo_q        <= '0;
            count_q       <= 2'd0;
            mode_q        <= MODE_RUN;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_v_q  <= inflight_v_d;
            inflight_pc_q <= inflight_pc_d;
            fifo_q        <= fifo_d;
            count_q       <= count_d;
            mode_q        <= mode_d;
        end
    end

endmodule

// File: tb/tb_rom_fetch_stage.sv
// Directed plus randomized bench for rom_fetch_stage against an attached ROM model
// and a sequential-PC reference model of the delivered instruction stream.
module tb_rom_fetch_stage;

    localparam int unsigned DEPTH  = 512;
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] o_rom_addr;
    logic [31:0]   rom_q;
    logic          i_redirect;
    logic [31:0]   i_redirect_pc;
    logic          o_valid;
    logic          i_ready;
    logic [31:0]   o_instr;
    logic [31:0]   o_pc;
    logic          o_fault;

    logic [31:0]   rom [DEPTH];

    int            tests;
    int            failures;
    logic [31:0]   exp_pc;
    logic          faulted;

    rom_fetch_stage #(
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_rom_addr    (o_rom_addr),
        .i_rom_data    (rom_q),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .o_fault       (o_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM with registered address: data appears the cycle after the address
    always_ff @(posedge clk) rom_q <= rom[o_rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic target_ok(input logic [31:0] pc);
        return (pc % 4 == 0) && (pc < DEPTH * 4);
    endfunction

    // One clock cycle: drive, check against the model, advance the model, step the clock.
    // ev/ef: expected o_valid/o_fault, 2 = don't care.
    task automatic cyc(input logic rdy, input logic rd, input logic [31:0] rpc,
                       input int ev, input int ef);
        logic [AW-1:0] idx;
        i_ready       = rdy;
        i_redirect    = rd;
        i_redirect_pc = rpc;
        #1;
        if (ev != 2) chk("valid", 32'(o_valid), 32'(ev));
        if (ef != 2) chk("fault", 32'(o_fault), 32'(ef));
        if (faulted) begin
            chk("fault_hold_valid", 32'(o_valid), 32'd0);
            chk("fault_hold_fault", 32'(o_fault), 32'd1);
        end
        if (o_fault) chk("fault_excl_valid", 32'(o_valid), 32'd0);
        if (o_valid) begin
            idx = exp_pc[AW+1:2];
            chk("pc", o_pc, exp_pc);
            chk("instr", o_instr, rom[idx]);
        end
        if (rd) chk("rom_addr_redirect", 32'(o_rom_addr), 32'(rpc[AW+1:2]));
        if (rd) begin
            exp_pc  = rpc;
            faulted = !target_ok(rpc);
        end else if (o_valid && rdy) begin
            exp_pc = exp_pc + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse landing mid-cycle; release starts a new cycle 0
    task automatic async_reset();
        i_redirect = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_fault", 32'(o_fault), 32'd0);
        chk("rst_pc", o_pc, 32'd0);
        chk("rst_instr", o_instr, 32'd0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_pc  = RST_PC;
        faulted = 1'b0;
    endtask

    initial begin
        logic [31:0] tgt;
        int          kind;
        tests         = 0;
        failures      = 0;
        exp_pc        = RST_PC;
        faulted       = 1'b0;
        rst_n         = 1'b0;
        i_ready       = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'd0;
        for (int k = 0; k < int'(DEPTH); k++) rom[k] = {16'($urandom), 16'(k)};

        // Held in reset
        #12;
        chk("reset_valid", 32'(o_valid), 32'd0);
        chk("reset_fault", 32'(o_fault), 32'd0);
        chk("reset_pc", o_pc, 32'd0);
        chk("reset_instr", o_instr, 32'd0);
        chk("reset_rom_addr", 32'(o_rom_addr), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First valid in cycle 2, then one per cycle
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(1, 0, 0, 1, 0);

        // Random backpressure, no redirects
        for (int i = 0; i < 60; i++) cyc(1'($urandom_range(0, 1)), 0, 0, 2, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 2, 0);

        // Ten-cycle stall then skid release with no bubble
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 12; i++) cyc(1, 0, 0, 1, 0);

        // Redirect to 0x40 with buffered work and a handshake in the same cycle
        cyc(0, 0, 0, 1, 0);
        cyc(1, 1, 32'h40, 1, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);

        // Misaligned target faults; aligned redirect recovers
        cyc(1, 1, 32'h42, 1, 0);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(1, 1, 32'h10, 0, 1);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);

        // Out-of-range target faults; async reset clears the fault
        cyc(1, 1, 32'h800, 1, 0);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        async_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 0);

        // Run off the end of the ROM
        cyc(1, 1, 32'h7F0, 1, 0);
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 1);

        // Random redirects and backpressure
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                kind = int'($urandom_range(0, 7));
                case (kind)
                    0:       tgt = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
                    1:       tgt = 32'h800 + (32'($urandom_range(0, 1000)) << 2);
                    2:       tgt = 32'($urandom_range(DEPTH - 12, DEPTH - 1)) << 2;
                    default: tgt = 32'($urandom_range(0, DEPTH - 1)) << 2;
                endcase
                cyc(1'($urandom_range(0, 1)), 1, tgt, 2, 2);
            end else begin
                cyc(1'($urandom_range(0, 3) != 0), 0, 0, 2, 2);
            end
        end

        // Async reset mid-stream
        cyc(1, 1, 32'h100, 2, 2);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);
        async_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
